// File: rtl/vc_req_buffer.sv
// vc_req_buffer: input-side virtual-channel buffer acting as a requester for a
// round-robin arbiter. Flits are queued in a small FIFO; a head flit at the
// front raises req_o, the granted packet drains wormhole-style, and update_i_o
// pulses on the tail handshake so the arbiter can rotate its priority.
module vc_req_buffer #(
    parameter int unsigned FLIT_WIDTH = 34,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid_i,
    input  logic [FLIT_WIDTH-1:0]    in_flit_i,
    output logic                     in_ready_o,
    output logic                     req_o,
    input  logic                     grant_i,
    output logic                     update_i_o,
    output logic                     out_valid_o,
    output logic [FLIT_WIDTH-1:0]    out_flit_o,
    input  logic                     out_ready_i,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     proto_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        FT_HEAD      = 2'b00,
        FT_BODY      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER
    } state_e;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    state_e                state;
    logic                  first_flit;

    flit_type_e            head_type;
    logic                  head_is_head;
    logic                  head_is_tail;
    logic                  push;
    logic                  pop;
    logic                  pop_out;
    logic                  drop;

    // FIFO status and head-of-queue decode
    always_comb begin
        empty_o      = (count_o == '0);
        full_o       = (count_o == FULL_CNT);
        in_ready_o   = !full_o;
        out_flit_o   = mem[rd_ptr];
        head_type    = flit_type_e'(out_flit_o[FLIT_WIDTH-1 -: 2]);
        head_is_head = (head_type == FT_HEAD) || (head_type == FT_HEAD_TAIL);
        head_is_tail = (head_type == FT_TAIL) || (head_type == FT_HEAD_TAIL);
    end

    // Handshakes: downstream pops only while the packet holds the grant;
    // stray non-head flits at the front of an idle buffer are popped internally.
    always_comb begin
        req_o       = (state == S_REQ) || (state == S_XFER);
        out_valid_o = (state == S_XFER) && !empty_o && grant_i;
        pop_out     = out_valid_o && out_ready_i;
        update_i_o  = pop_out && head_is_tail;
        drop        = (state == S_IDLE) && !empty_o && !head_is_head;
        push        = in_valid_i && in_ready_o;
        pop         = pop_out || drop;
    end

    // Flit storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    // Request FSM with packet lock and sticky protocol-error flag
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= S_IDLE;
            first_flit  <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty_o) begin
                        if (head_is_head) begin
                            state <= S_REQ;
                        end else begin
                            proto_err_o <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (grant_i) begin
                        state      <= S_XFER;
                        first_flit <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (pop_out) begin
                        first_flit <= 1'b0;
                        if (head_is_head && !first_flit) begin
                            proto_err_o <= 1'b1;
                        end
                        if (head_is_tail) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_req_buffer.sv
// Testbench for vc_req_buffer: per-cycle vector table plus a back-to-back
// single-flit packet sequence with an in-order scoreboard.
module tb_vc_req_buffer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        in_valid = 1'b0;
    logic [33:0] in_flit = '0;
    logic        in_ready;
    logic        req;
    logic        grant = 1'b0;
    logic        update;
    logic        out_valid;
    logic [33:0] out_flit;
    logic        out_ready = 1'b0;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        proto_err;

    int tests = 0;
    int fails = 0;

    vc_req_buffer #(.FLIT_WIDTH(34), .DEPTH(4)) dut (
        .clk         (clk),
        .arst        (arst),
        .in_valid_i  (in_valid),
        .in_flit_i   (in_flit),
        .in_ready_o  (in_ready),
        .req_o       (req),
        .grant_i     (grant),
        .update_i_o  (update),
        .out_valid_o (out_valid),
        .out_flit_o  (out_flit),
        .out_ready_i (out_ready),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (count),
        .proto_err_o (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [33:0] fl;
        logic        g;
        logic        rdy;
        logic        req;
        logic        ov;
        logic        upd;
        logic [2:0]  cnt;
        logic        err;
        logic        cf;
        logic [33:0] ef;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic rst, logic iv, logic [33:0] fl,
                                logic g, logic rdy, logic e_req, logic e_ov,
                                logic e_upd, logic [2:0] e_cnt, logic e_err,
                                logic cf, logic [33:0] ef);
        vec_t v;
        v.name = n; v.rst = rst; v.iv = iv; v.fl = fl; v.g = g; v.rdy = rdy;
        v.req = e_req; v.ov = e_ov; v.upd = e_upd; v.cnt = e_cnt; v.err = e_err;
        v.cf = cf; v.ef = ef;
        vecs.push_back(v);
    endfunction

    localparam logic [33:0] HT1 = 34'h3_0000_0011;
    localparam logic [33:0] H2  = 34'h0_0000_00A0;
    localparam logic [33:0] B2A = 34'h1_0000_00A1;
    localparam logic [33:0] B2B = 34'h1_0000_00A2;
    localparam logic [33:0] T2  = 34'h2_0000_00A3;
    localparam logic [33:0] H3  = 34'h0_0000_00B0;
    localparam logic [33:0] B3  = 34'h1_0000_00B1;
    localparam logic [33:0] T3  = 34'h2_0000_00B2;
    localparam logic [33:0] B4  = 34'h1_0000_00C0;
    localparam logic [33:0] H5  = 34'h0_0000_00D0;
    localparam logic [33:0] B5A = 34'h1_0000_00D1;
    localparam logic [33:0] B5B = 34'h1_0000_00D2;
    localparam logic [33:0] T5  = 34'h2_0000_00D3;
    localparam logic [33:0] HT5 = 34'h3_0000_00E0;

    logic [9:0] act_v;
    logic [9:0] exp_v;

    initial begin
        // name   rst iv flit g rdy | req ov upd cnt err cf flit
        add("reset",  0,0,'0, 0,0, 0,0,0,0,0, 0,'0);
        // single HEAD_TAIL packet
        add("t1c0",   1,1,HT1,1,1, 0,0,0,0,0, 0,'0);
        add("t1c1",   1,0,'0, 1,1, 0,0,0,1,0, 0,'0);
        add("t1c2",   1,0,'0, 1,1, 1,0,0,1,0, 0,'0);
        add("t1c3",   1,0,'0, 1,1, 1,1,1,1,0, 1,HT1);
        add("t1c4",   1,0,'0, 1,1, 0,0,0,0,0, 0,'0);
        // four-flit packet, grant withheld until FIFO full
        add("t2c0",   1,1,H2, 0,1, 0,0,0,0,0, 0,'0);
        add("t2c1",   1,1,B2A,0,1, 0,0,0,1,0, 0,'0);
        add("t2c2",   1,1,B2B,0,1, 1,0,0,2,0, 0,'0);
        add("t2c3",   1,1,T2, 0,1, 1,0,0,3,0, 0,'0);
        for (int i = 0; i < 5; i++)
            add($sformatf("t2hold%0d", i), 1,0,'0, 0,1, 1,0,0,4,0, 0,'0);
        add("t2c9",   1,0,'0, 1,1, 1,0,0,4,0, 0,'0);
        add("t2c10",  1,0,'0, 1,1, 1,1,0,4,0, 1,H2);
        add("t2c11",  1,0,'0, 1,1, 1,1,0,3,0, 1,B2A);
        add("t2c12",  1,0,'0, 1,1, 1,1,0,2,0, 1,B2B);
        add("t2c13",  1,0,'0, 1,1, 1,1,1,1,0, 1,T2);
        add("t2c14",  1,0,'0, 1,1, 0,0,0,0,0, 0,'0);
        // backpressure and grant loss mid-packet
        add("t3c0",   1,1,H3, 1,1, 0,0,0,0,0, 0,'0);
        add("t3c1",   1,1,B3, 1,1, 0,0,0,1,0, 0,'0);
        add("t3c2",   1,1,T3, 1,1, 1,0,0,2,0, 0,'0);
        add("t3c3",   1,0,'0, 1,1, 1,1,0,3,0, 1,H3);
        add("t3c4",   1,0,'0, 1,0, 1,1,0,2,0, 1,B3);
        add("t3c5",   1,0,'0, 1,1, 1,1,0,2,0, 1,B3);
        add("t3c6",   1,0,'0, 0,1, 1,0,0,1,0, 0,'0);
        add("t3c7",   1,0,'0, 0,1, 1,0,0,1,0, 0,'0);
        add("t3c8",   1,0,'0, 1,1, 1,1,1,1,0, 1,T3);
        add("t3c9",   1,0,'0, 1,1, 0,0,0,0,0, 0,'0);
        // stray BODY into idle buffer
        add("t4c0",   1,1,B4, 1,1, 0,0,0,0,0, 0,'0);
        add("t4c1",   1,0,'0, 1,1, 0,0,0,1,0, 0,'0);
        add("t4c2",   1,0,'0, 1,1, 0,0,0,0,1, 0,'0);
        add("t4c3",   1,0,'0, 1,1, 0,0,0,0,1, 0,'0);
        // async reset mid-packet, then a clean packet
        add("t5c0",   1,1,H5, 1,1, 0,0,0,0,1, 0,'0);
        add("t5c1",   1,1,B5A,1,1, 0,0,0,1,1, 0,'0);
        add("t5c2",   1,1,B5B,1,1, 1,0,0,2,1, 0,'0);
        add("t5c3",   1,1,T5, 1,1, 1,1,0,3,1, 1,H5);
        add("t5c4",   1,0,'0, 1,1, 1,1,0,3,1, 1,B5A);
        add("t5rst",  0,0,'0, 1,1, 0,0,0,0,0, 0,'0);
        add("t5c6",   1,1,HT5,1,1, 0,0,0,0,0, 0,'0);
        add("t5c7",   1,0,'0, 1,1, 0,0,0,1,0, 0,'0);
        add("t5c8",   1,0,'0, 1,1, 1,0,0,1,0, 0,'0);
        add("t5c9",   1,0,'0, 1,1, 1,1,1,1,0, 1,HT5);
        add("t5c10",  1,0,'0, 1,1, 0,0,0,0,0, 0,'0);

        // Inputs change on the falling edge; outputs checked 1ns later,
        // so a vector with rst=0 observes reset without any rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            arst      = vecs[i].rst;
            in_valid  = vecs[i].iv;
            in_flit   = vecs[i].fl;
            grant     = vecs[i].g;
            out_ready = vecs[i].rdy;
            #1;
            act_v = {req, out_valid, update, count, empty, full, in_ready, proto_err};
            exp_v = {vecs[i].req, vecs[i].ov, vecs[i].upd, vecs[i].cnt,
                     vecs[i].cnt == 3'd0, vecs[i].cnt == 3'd4,
                     vecs[i].cnt != 3'd4, vecs[i].err};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL %s: req/ov/upd/cnt/empty/full/rdy/err actual=%b required=%b",
                         vecs[i].name, act_v, exp_v);
            end
            if (vecs[i].cf) begin
                tests++;
                if (out_flit !== vecs[i].ef) begin
                    fails++;
                    $display("FAIL %s_flit: actual=%h required=%h",
                             vecs[i].name, out_flit, vecs[i].ef);
                end
            end
        end

        // Seven back-to-back single-flit packets: wraps the pointers
        begin
            logic [33:0] expq[$];
            logic [33:0] want;
            int sent = 0;
            int rcvd = 0;
            int upds = 0;
            for (int cyc = 0; cyc < 200 && rcvd < 7; cyc++) begin
                @(negedge clk);
                grant     = 1'b1;
                out_ready = 1'b1;
                in_valid  = (sent < 7);
                in_flit   = {2'b11, 32'(32'h600 + sent)};
                #1;
                if (update) upds++;
                if (out_valid && out_ready) begin
                    want = (expq.size() > 0) ? expq.pop_front() : '1;
                    tests++;
                    if (out_flit !== want) begin
                        fails++;
                        $display("FAIL t6_flit%0d: actual=%h required=%h",
                                 rcvd, out_flit, want);
                    end
                    rcvd++;
                end
                if (in_valid && in_ready) begin
                    expq.push_back(in_flit);
                    sent++;
                end
            end
            in_valid = 1'b0;
            tests++;
            if (rcvd != 7) begin
                fails++;
                $display("FAIL t6_timeout: received=%0d required=7", rcvd);
            end
            tests++;
            if (upds != 7) begin
                fails++;
                $display("FAIL t6_updates: actual=%0d required=7", upds);
            end
            @(negedge clk);
            #1;
            tests++;
            if ({req, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
                fails++;
                $display("FAIL t6_idle: req/cnt/empty actual=%b required=%b",
                         {req, count, empty}, {1'b0, 3'd0, 1'b1});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
